sample_loop_player: RTL

- Record/playback buffer for the 12-bit audio sample stream; the replay counterpart to the fixed-offset delay line.
- Captures a sample run into block RAM on command, then reads it back on demand, once or looped.
- Sits between the mic sample path and the output/DAC mux; all sample movement is gated by the sample-rate strobe.

---
 rtl/sample_loop_player_pkg.sv | 14 +
 rtl/sample_loop_player_ram.sv | 26 ++
 rtl/sample_loop_player.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sample_loop_player_pkg.sv
// Shared audio definitions for the sample loop player: sample width,
// silence level and the FSM state encoding seen on the state output.
package sample_loop_player_pkg;

   localparam int SAMPLE_W = 12;
   localparam logic [SAMPLE_W-1:0] SAMPLE_MIDSCALE = 12'h800;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RECORD = 2'b01,
      ST_PLAY   = 2'b10
   } player_state_t;

endpackage

// File: rtl/sample_loop_player_ram.sv
// Single-port synchronous sample buffer with registered read (1-cycle latency).
// Contents and read register are deliberately left unreset so it maps onto BRAM.
module sample_ram
   import sample_loop_player_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int AW     = 15,
   parameter int DEPTH  = 32768
) (
   input  logic              CLOCK,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLOCK) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/sample_loop_player.sv
// Record/playback buffer for the 12-bit sample stream: captures a run of
// samples on command, then replays it once or looped, paced by SAMPLE_EN.
module sample_loop_player
   import sample_loop_player_pkg::*;
#(
   parameter int                DATA_W   = SAMPLE_W,
   parameter int                ADDR_W   = 15,
   parameter int                DEPTH    = 32768,
   parameter logic [DATA_W-1:0] MIDSCALE = SAMPLE_MIDSCALE
) (
   input  logic              CLOCK,
   input  logic              RESETN,
   input  logic              SAMPLE_EN,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rec_start,
   input  logic              play_start,
   input  logic              stop,
   input  logic              loop,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   rec_len,
   output logic              full
);

   localparam int              RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   player_state_t      state_q, state_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [RAM_AW-1:0]  rd_addr_q, rd_addr_d;
   logic [ADDR_W:0]    rec_len_q, rec_len_d;
   logic               full_q, full_d;
   logic               out_valid_q, out_valid_d;
   logic               out_sel_q, out_sel_d;
   logic               last_q, last_d;
   logic               rd_issue;
   logic               ram_we;
   logic [RAM_AW-1:0]  ram_addr;
   logic [DATA_W-1:0]  ram_dout;

   // out_valid is a one-cycle pulse, no back-pressure: it rises exactly one
   // CLOCK after the SAMPLE_EN that issued the read, and data_out carries
   // that sample for as long as the player stays in PLAY without a new read.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_addr_d   = rd_addr_q;
      rec_len_d   = rec_len_q;
      full_d      = full_q;
      last_d      = last_q;
      out_valid_d = 1'b0;
      rd_issue    = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = rd_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (rec_start) begin
               state_d   = ST_RECORD;
               wr_ptr_d  = '0;
               full_d    = 1'b0;
               rec_len_d = '0;
            end else if (play_start && (rec_len_q != '0)) begin
               state_d  = ST_PLAY;
               rd_ptr_d = '0;
               last_d   = 1'b0;
            end
         end

         ST_RECORD: begin
            ram_addr = wr_ptr_q[RAM_AW-1:0];
            if (stop) begin
               state_d = ST_IDLE;
            end else if (SAMPLE_EN) begin
               ram_we = 1'b1;
               if (wr_ptr_q == LAST_ADDR) begin
                  full_d    = 1'b1;
                  rec_len_d = DEPTH_L;
                  state_d   = ST_IDLE;
               end else begin
                  wr_ptr_d  = wr_ptr_q + 1'b1;
                  rec_len_d = {1'b0, wr_ptr_q} + 1'b1;
               end
            end
         end

         ST_PLAY: begin
            // last_q marks the cycle where the final sample is on data_out
            if (stop || last_q) begin
               state_d = ST_IDLE;
            end else if (SAMPLE_EN) begin
               rd_issue    = 1'b1;
               out_valid_d = 1'b1;
               ram_addr    = rd_ptr_q[RAM_AW-1:0];
               rd_addr_d   = rd_ptr_q[RAM_AW-1:0];
               if ({1'b0, rd_ptr_q} == (rec_len_q - 1'b1)) begin
                  if (loop) begin
                     rd_ptr_d = '0;
                  end else begin
                     last_d = 1'b1;
                  end
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      out_sel_d = (state_d == ST_PLAY) && (rd_issue || out_sel_q);
   end

   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_addr_q   <= '0;
         rec_len_q   <= '0;
         full_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sel_q   <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_addr_q   <= rd_addr_d;
         rec_len_q   <= rec_len_d;
         full_q      <= full_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
         last_q      <= last_d;
      end
   end

   // The read address is held between strobes, so the RAM read register
   // itself keeps the current sample stable on data_out.
   sample_ram #(
      .DATA_W (DATA_W),
      .AW     (RAM_AW),
      .DEPTH  (DEPTH)
   ) u_ram (
      .CLOCK (CLOCK),
      .we    (ram_we),
      .addr  (ram_addr),
      .din   (data_in),
      .dout  (ram_dout)
   );

   assign data_out  = out_sel_q ? ram_dout : MIDSCALE;
   assign out_valid = out_valid_q;
   assign state     = state_q;
   assign rec_len   = rec_len_q;
   assign full      = full_q;

endmodule
